// File: rtl/uart_rx.sv
// UART receiver with a bus-mapped register file and a byte FIFO.
// Registers: CTRL 0x0, STATUS 0x4, BAUD 0x8, RXDATA 0xC (read pops one byte).
module uart_rx #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BAUD_RESET = 32'h1B3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  input  logic        rx_pin
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1'b1);

  logic [1:0]    sync_r;
  logic          rx_s;
  logic          rx_prev_r;
  logic          en_r;
  logic          ovf_r;
  logic          ferr_r;
  logic [31:0]   baud_r;
  logic [1:0]    state_r;
  logic [15:0]   cnt_r;
  logic [7:0]    shift_r;
  logic [2:0]    bit_cnt_r;
  logic          ferr_wait_r;
  logic          push_r;
  logic [7:0]    push_data_r;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [AW:0]   count_r;

  logic wr_ctrl_s, wr_status_s, wr_baud_s, rd_pop_s, flush_s;
  logic full_s, empty_s, pop_s, push_ok_s, drop_s;
  logic half_s, samp_s, ferr_set_s, busy_s;
  logic [5:0] cnt6_s;
  logic unused_s;

  assign rx_s     = sync_r[1];
  assign ack_o    = req_i;
  assign unused_s = ^addr_i[31:4];

  // Bus decode, FIFO handshake and bit-timing compare terms
  always_comb begin
    wr_ctrl_s   = req_i & we_i & (addr_i[3:0] == 4'h0);
    wr_status_s = req_i & we_i & (addr_i[3:0] == 4'h4);
    wr_baud_s   = req_i & we_i & (addr_i[3:0] == 4'h8);
    rd_pop_s    = req_i & ~we_i & (addr_i[3:0] == 4'hC);
    flush_s     = wr_ctrl_s & data_i[1];
    full_s      = count_r[AW];
    empty_s     = ~|count_r;
    pop_s       = rd_pop_s & ~empty_s;
    // A full FIFO still accepts a byte when a pop frees the slot this cycle
    push_ok_s   = push_r & (~full_s | pop_s);
    drop_s      = push_r & full_s & ~pop_s;
    half_s      = (cnt_r == {1'b0, baud_r[15:1]});
    samp_s      = (cnt_r == baud_r[15:0]);
    ferr_set_s  = en_r & (state_r == ST_STOP) & ~ferr_wait_r & samp_s & ~rx_s;
    busy_s      = (state_r != ST_IDLE);
    cnt6_s      = 6'(count_r);
  end

  // Two-flop synchronizer plus previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r    <= 2'b11;
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[0], rx_pin};
      rx_prev_r <= rx_s;
    end
  end

  // Control, baud and sticky status registers; set wins over clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_r   <= 1'b0;
      baud_r <= BAUD_RESET;
      ovf_r  <= 1'b0;
      ferr_r <= 1'b0;
    end else begin
      if (wr_ctrl_s) en_r <= data_i[0];
      if (wr_baud_s) baud_r <= data_i;
      if (drop_s && !flush_s) ovf_r <= 1'b1;
      else if (wr_status_s && data_i[2]) ovf_r <= 1'b0;
      if (ferr_set_s) ferr_r <= 1'b1;
      else if (wr_status_s && data_i[3]) ferr_r <= 1'b0;
    end
  end

  // Receive FSM: half-period start check, then full-period data/stop samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      shift_r     <= 8'd0;
      bit_cnt_r   <= 3'd0;
      ferr_wait_r <= 1'b0;
      push_r      <= 1'b0;
      push_data_r <= 8'd0;
    end else begin
      push_r <= 1'b0;
      if (!en_r) begin
        state_r     <= ST_IDLE;
        cnt_r       <= 16'd0;
        bit_cnt_r   <= 3'd0;
        ferr_wait_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (rx_prev_r && !rx_s) begin
              state_r <= ST_START;
              cnt_r   <= 16'd0;
            end
          end
          ST_START: begin
            if (half_s) begin
              cnt_r     <= 16'd0;
              bit_cnt_r <= 3'd0;
              state_r   <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
          ST_DATA: begin
            if (samp_s) begin
              cnt_r     <= 16'd0;
              shift_r   <= {rx_s, shift_r[7:1]};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) state_r <= ST_STOP;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
          ST_STOP: begin
            // After a bad stop bit, wait for the line to return high
            if (ferr_wait_r) begin
              if (rx_s) begin
                ferr_wait_r <= 1'b0;
                state_r     <= ST_IDLE;
              end
            end else if (samp_s) begin
              cnt_r <= 16'd0;
              if (rx_s) begin
                push_r      <= 1'b1;
                push_data_r <= shift_r;
                state_r     <= ST_IDLE;
              end else begin
                ferr_wait_r <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush_s) mem_r[wptr_r] <= push_data_r;
  end

  // FIFO pointers and occupancy; flush overrides push and pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else if (flush_s) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wptr_r <= wptr_r + PTR_ONE;
      if (pop_s) rptr_r <= rptr_r + PTR_ONE;
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Combinational read mux, forced to zero while in reset
  always_comb begin
    data_o = 32'd0;
    if (!rst) begin
      data_o = 32'd0;
    end else begin
      case (addr_i[3:0])
        4'h0:    data_o = {31'd0, en_r};
        4'h4:    data_o = {18'd0, cnt6_s, 3'd0, busy_s, ferr_r, ovf_r, full_s, ~empty_s};
        4'h8:    data_o = baud_r;
        4'hC: begin
          if (!empty_s) data_o = {24'd0, mem_r[rptr_r]};
          else data_o = 32'd0;
        end
        default: data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: serial frames driven on rx_pin,
// results read back over the register bus.
module tb_uart_rx;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic        req_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        rx_pin;

  int vectors;
  int miscompares;

  uart_rx #(.FIFO_DEPTH(16), .BAUD_RESET(32'h1B3)) dut (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we_i),
    .req_i  (req_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .ack_o  (ack_o),
    .rx_pin (rx_pin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    req_i  = 1'b1;
    we_i   = 1'b1;
    addr_i = {28'd0, a};
    data_i = d;
    @(negedge clk);
    req_i  = 1'b0;
    we_i   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = {28'd0, a};
    #1 check(tag, data_o, exp);
    @(negedge clk);
    req_i  = 1'b0;
  endtask

  // act: 0 none, 1 RXDATA read at clock 'at', 2 CTRL=0 write at 'at', 3 reset pulse at 'at'
  task automatic send(input logic [7:0] b, input int per, input logic stop,
                      input int act, input int at, input logic [31:0] pexp);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int n = 0; n < 10 * per; n++) begin
      @(negedge clk);
      rx_pin = fr[n / per];
      if (act != 0 && n == at) begin
        case (act)
          1: begin
            req_i = 1'b1; we_i = 1'b0; addr_i = 32'hC;
            #1 check("pop_during_push", data_o, pexp);
          end
          2: begin
            req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; data_i = 32'h0;
          end
          default: begin
            rst = 1'b0; addr_i = 32'h8;
            #1 check("rst_midframe_data", data_o, 32'h0);
          end
        endcase
      end else if (act != 0 && n == at + 1) begin
        req_i = 1'b0;
        we_i  = 1'b0;
        rst   = 1'b1;
      end
    end
    @(negedge clk);
    rx_pin = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    clk = 1'b0; rst = 1'b0; we_i = 1'b0; req_i = 1'b0;
    addr_i = 32'h8; data_i = 32'h0; rx_pin = 1'b1;

    // reset state
    #2 check("rst_data_o", data_o, 32'h0);
    req_i = 1'b1;
    #1 check("ack_hi", {31'd0, ack_o}, 32'h1);
    req_i = 1'b0;
    #1 check("ack_lo", {31'd0, ack_o}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rd_chk("rst_ctrl", 4'h0, 32'h0);
    rd_chk("rst_status", 4'h4, 32'h0);
    rd_chk("rst_baud", 4'h8, 32'h1B3);
    rd_chk("rst_rxdata", 4'hC, 32'h0);
    rd_chk("unmapped", 4'h2, 32'h0);
    bus_write(4'h0, 32'hFFFF_FFFF);
    rd_chk("ctrl_en", 4'h0, 32'h1);

    // basic receive at 436 clocks/bit
    send(8'h55, 436, 1'b1, 0, 0, 32'h0);
    rd_chk("basic_status", 4'h4, 32'h101);
    rd_chk("basic_data", 4'hC, 32'h55);
    rd_chk("basic_status2", 4'h4, 32'h0);

    // glitch rejection
    @(negedge clk) rx_pin = 1'b0;
    repeat (50) @(negedge clk);
    rd_chk("glitch_busy", 4'h4, 32'h10);
    repeat (48) @(negedge clk);
    rx_pin = 1'b1;
    repeat (300) @(negedge clk);
    rd_chk("glitch_idle", 4'h4, 32'h0);

    // frame error
    send(8'hA3, 436, 1'b0, 0, 0, 32'h0);
    rd_chk("ferr_status", 4'h4, 32'h8);
    bus_write(4'h4, 32'h8);
    rd_chk("ferr_clear", 4'h4, 32'h0);

    // fast baud, upper bits stored
    bus_write(4'h8, 32'hABCD_000F);
    rd_chk("baud_rb", 4'h8, 32'hABCD_000F);

    // overflow
    for (int i = 0; i < 17; i++) send(8'(i), 16, 1'b1, 0, 0, 32'h0);
    rd_chk("ovf_status", 4'h4, 32'h1007);
    for (int i = 0; i < 16; i++) rd_chk("ovf_data", 4'hC, 32'(i));
    rd_chk("ovf_sticky", 4'h4, 32'h4);
    rd_chk("empty_read", 4'hC, 32'h0);
    bus_write(4'h4, 32'h4);
    rd_chk("ovf_clear", 4'h4, 32'h0);

    // push and pop together while full
    for (int i = 0; i < 16; i++) send(8'(32 + i), 16, 1'b1, 0, 0, 32'h0);
    rd_chk("full_status", 4'h4, 32'h1003);
    send(8'h30, 16, 1'b1, 1, 155, 32'h20);
    rd_chk("fullpop_status", 4'h4, 32'h1003);
    for (int i = 1; i < 17; i++) rd_chk("fullpop_data", 4'hC, 32'(32 + i));
    rd_chk("fullpop_empty", 4'h4, 32'h0);

    // flush
    send(8'h11, 16, 1'b1, 0, 0, 32'h0);
    send(8'h22, 16, 1'b1, 0, 0, 32'h0);
    rd_chk("flush_pre", 4'h4, 32'h201);
    bus_write(4'h0, 32'h3);
    rd_chk("flush_status", 4'h4, 32'h0);
    rd_chk("flush_ctrl", 4'h0, 32'h1);

    // disable mid-frame during data bit 3
    send(8'h5A, 16, 1'b1, 2, 72, 32'h0);
    rd_chk("dis_status", 4'h4, 32'h0);
    rd_chk("dis_ctrl", 4'h0, 32'h0);
    bus_write(4'h0, 32'h1);
    send(8'hC3, 16, 1'b1, 0, 0, 32'h0);
    rd_chk("dis_next_status", 4'h4, 32'h101);
    rd_chk("dis_next_data", 4'hC, 32'hC3);

    // reset mid-frame during data bit 3
    send(8'h5A, 16, 1'b1, 3, 72, 32'h0);
    rd_chk("rst2_status", 4'h4, 32'h0);
    rd_chk("rst2_baud", 4'h8, 32'h1B3);
    bus_write(4'h8, 32'hF);
    bus_write(4'h0, 32'h1);
    send(8'hC3, 16, 1'b1, 0, 0, 32'h0);
    rd_chk("rst2_next_status", 4'h4, 32'h101);
    rd_chk("rst2_next_data", 4'hC, 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
